// File: rtl/ninjakun_busarb.sv
// rtl/ninjakun_busarb.sv - multi-CPU address decoder and round-robin arbiter for shared video/sound devices
module ninjakun_busarb #(
    parameter int NCPU = 2,
    parameter int HOLD = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [1:0]           HWTYPE,
    input  logic [NCPU*16-1:0]   CPADR,
    input  logic [NCPU-1:0]      CPREQ,
    input  logic [NCPU-1:0]      CPWR,
    output logic [NCPU-1:0]      CPWAIT,
    output logic [15:0]          BUS_ADR,
    output logic                 BUS_WR,
    output logic [1:0]           GRANT,
    output logic                 CS_SCRX,
    output logic                 CS_SCRY,
    output logic                 CS_PSG,
    output logic                 CS_FGV,
    output logic                 CS_BGV,
    output logic                 CS_SPA,
    output logic                 CS_PAL
);

    localparam logic [1:0] HW_NINJAKUN = 2'd0;
    localparam logic [1:0] HW_RAIDERS5 = 2'd1;
    localparam logic [1:0] HW_NOVA2001 = 2'd2;
    localparam logic [1:0] HW_PKUNWAR  = 2'd3;

    localparam int B_SCRX = 6;
    localparam int B_SCRY = 5;
    localparam int B_PSG  = 4;
    localparam int B_FGV  = 3;
    localparam int B_BGV  = 2;
    localparam int B_SPA  = 1;
    localparam int B_PAL  = 0;

    localparam logic [1:0] RR_INIT   = 2'(NCPU - 1);
    localparam logic [1:0] HOLD_LAST = 2'(HOLD - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [1:0]  rr;
    logic [1:0]  cnt;
    logic [6:0]  cs_q;

    logic [6:0]  region [NCPU];
    logic [NCPU-1:0] hit;
    logic        found;
    logic [1:0]  pick;
    logic [6:0]  pick_cs;
    logic [15:0] pick_adr;
    logic        pick_wr;
    logic        gnt_req;

    // Region vector bit order: SCRX, SCRY, PSG, FGV, BGV, SPA, PAL
    function automatic logic [6:0] decode(input logic [1:0] hw, input logic sub, input logic [15:0] a);
        logic [4:0] blk;
        logic [6:0] r;
        blk = a[15:11];
        r   = '0;
        case (hw)
            HW_RAIDERS5: begin
                if (!sub) begin
                    r[B_SCRX] = (a == 16'hA000);
                    r[B_SCRY] = (a == 16'hA001);
                    r[B_SPA]  = (blk == 5'h10);
                    r[B_FGV]  = (blk == 5'h11);
                    r[B_BGV]  = (blk == 5'h12);
                    r[B_PSG]  = (a[15:2] == 14'h3000);
                    r[B_PAL]  = (blk == 5'h1A);
                end else begin
                    r[B_SCRX] = (a == 16'hE000);
                    r[B_SCRY] = (a == 16'hE001);
                    r[B_PSG]  = (a[15:2] == 14'h2000);
                end
            end
            HW_NOVA2001: begin
                if (!sub) begin
                    r[B_FGV] = (blk == 5'h14);
                    r[B_BGV] = (blk == 5'h15);
                    r[B_SPA] = (blk == 5'h16);
                    r[B_PSG] = (a[15:2] == 14'h3000);
                end
            end
            HW_PKUNWAR: begin
                if (!sub) begin
                    r[B_SPA] = (blk == 5'h10);
                    r[B_BGV] = (blk == 5'h11);
                    r[B_PSG] = (a[15:2] == 14'h2800);
                end
            end
            default: begin
                r[B_PSG] = (a[15:2] == 14'h2000);
                r[B_FGV] = (blk == 5'h18);
                r[B_BGV] = (blk == 5'h19);
                r[B_SPA] = (blk == 5'h1A);
                r[B_PAL] = (blk == 5'h1B);
            end
        endcase
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NCPU; i++) begin
            region[i] = decode(HWTYPE, i != 0, CPADR[16*i +: 16]);
            hit[i]    = CPREQ[i] & (|region[i]);
        end
    end

    // Scan rr+1, rr+2, ... so the last winner drops to lowest priority
    always_comb begin
        found    = 1'b0;
        pick     = rr;
        pick_cs  = '0;
        pick_adr = '0;
        pick_wr  = 1'b0;
        for (int k = 1; k <= NCPU; k++) begin
            for (int i = 0; i < NCPU; i++) begin
                if (!found && hit[i] && (i == (int'(rr) + k) % NCPU)) begin
                    found    = 1'b1;
                    pick     = 2'(i);
                    pick_cs  = region[i];
                    pick_adr = CPADR[16*i +: 16];
                    pick_wr  = CPWR[i];
                end
            end
        end
    end

    always_comb begin
        gnt_req = 1'b0;
        for (int i = 0; i < NCPU; i++) begin
            if (GRANT == 2'(i)) begin
                gnt_req = CPREQ[i];
            end
            CPWAIT[i] = hit[i] & ~((state == ACCESS) && (GRANT == 2'(i)) && (cnt == HOLD_LAST));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            rr      <= RR_INIT;
            GRANT   <= 2'd0;
            cnt     <= 2'd0;
            cs_q    <= '0;
            BUS_ADR <= '0;
            BUS_WR  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= ACCESS;
                        GRANT   <= pick;
                        rr      <= pick;
                        cnt     <= 2'd0;
                        cs_q    <= pick_cs;
                        BUS_ADR <= pick_adr;
                        BUS_WR  <= pick_wr;
                    end
                end
                default: begin
                    if (!gnt_req || cnt == HOLD_LAST) begin
                        state <= IDLE;
                        cs_q  <= '0;
                        cnt   <= 2'd0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
            endcase
        end
    end

    assign CS_SCRX = cs_q[B_SCRX];
    assign CS_SCRY = cs_q[B_SCRY];
    assign CS_PSG  = cs_q[B_PSG];
    assign CS_FGV  = cs_q[B_FGV];
    assign CS_BGV  = cs_q[B_BGV];
    assign CS_SPA  = cs_q[B_SPA];
    assign CS_PAL  = cs_q[B_PAL];

endmodule

// File: tb/tb_ninjakun_busarb.sv
// tb/tb_ninjakun_busarb.sv - directed table-driven bench for ninjakun_busarb (NCPU=2, HOLD=2)
module tb_ninjakun_busarb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  HWTYPE;
    logic [15:0] adr0, adr1;
    logic [1:0]  CPREQ, CPWR;
    logic [1:0]  CPWAIT;
    logic [15:0] BUS_ADR;
    logic        BUS_WR;
    logic [1:0]  GRANT;
    logic        CS_SCRX, CS_SCRY, CS_PSG, CS_FGV, CS_BGV, CS_SPA, CS_PAL;
    logic [6:0]  cs;

    int n_chk  = 0;
    int n_fail = 0;

    ninjakun_busarb #(.NCPU(2), .HOLD(2)) dut (
        .CLK(CLK), .RESET(RESET), .HWTYPE(HWTYPE),
        .CPADR({adr1, adr0}), .CPREQ(CPREQ), .CPWR(CPWR),
        .CPWAIT(CPWAIT), .BUS_ADR(BUS_ADR), .BUS_WR(BUS_WR), .GRANT(GRANT),
        .CS_SCRX(CS_SCRX), .CS_SCRY(CS_SCRY), .CS_PSG(CS_PSG), .CS_FGV(CS_FGV),
        .CS_BGV(CS_BGV), .CS_SPA(CS_SPA), .CS_PAL(CS_PAL)
    );

    assign cs = {CS_SCRX, CS_SCRY, CS_PSG, CS_FGV, CS_BGV, CS_SPA, CS_PAL};

    always #5 CLK = ~CLK;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_SCRX = 7'b1000000;
    localparam logic [6:0] C_SCRY = 7'b0100000;
    localparam logic [6:0] C_PSG  = 7'b0010000;
    localparam logic [6:0] C_FGV  = 7'b0001000;
    localparam logic [6:0] C_BGV  = 7'b0000100;
    localparam logic [6:0] C_SPA  = 7'b0000010;
    localparam logic [6:0] C_PAL  = 7'b0000001;

    typedef struct {
        logic [1:0]  hw;
        int          port;
        logic [15:0] adr;
        logic        wr;
        logic [6:0]  exp_cs;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        CPREQ = 2'b00;
        CPWR  = 2'b00;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{2'd0, 0, 16'hC123, 1'b0, C_FGV};
        tbl[1]  = '{2'd0, 1, 16'h8002, 1'b1, C_PSG};
        tbl[2]  = '{2'd0, 0, 16'hDFFF, 1'b0, C_PAL};
        tbl[3]  = '{2'd0, 0, 16'h8004, 1'b0, C_NONE};
        tbl[4]  = '{2'd1, 0, 16'hA001, 1'b1, C_SCRY};
        tbl[5]  = '{2'd1, 1, 16'hE000, 1'b1, C_SCRX};
        tbl[6]  = '{2'd1, 0, 16'h8400, 1'b0, C_SPA};
        tbl[7]  = '{2'd1, 0, 16'h9000, 1'b0, C_BGV};
        tbl[8]  = '{2'd1, 0, 16'hA002, 1'b0, C_NONE};
        tbl[9]  = '{2'd2, 1, 16'hA000, 1'b0, C_NONE};
        tbl[10] = '{2'd2, 0, 16'h0100, 1'b0, C_NONE};
        tbl[11] = '{2'd2, 0, 16'hA7FF, 1'b1, C_FGV};
        tbl[12] = '{2'd3, 0, 16'hA003, 1'b0, C_PSG};
        tbl[13] = '{2'd3, 0, 16'h8800, 1'b0, C_BGV};
        tbl[14] = '{2'd3, 1, 16'h8000, 1'b0, C_NONE};

        // Reset state, with a device hit presented during reset
        RESET  = 1'b1;
        HWTYPE = 2'd0;
        adr0   = 16'hC000;
        adr1   = 16'h0000;
        CPREQ  = 2'b01;
        CPWR   = 2'b00;
        tick();
        tick();
        chk("rst_cs", 32'(cs), 32'(C_NONE));
        chk("rst_adr", 32'(BUS_ADR), 32'h0);
        chk("rst_wr", 32'(BUS_WR), 32'h0);
        chk("rst_grant", 32'(GRANT), 32'h0);
        chk("rst_wait", 32'(CPWAIT), 32'h1);
        do_reset();

        // Single-requester vectors
        for (int r = 0; r < 15; r++) begin
            logic [1:0] pbit;
            pbit   = (tbl[r].port == 0) ? 2'b01 : 2'b10;
            HWTYPE = tbl[r].hw;
            adr0   = (tbl[r].port == 0) ? tbl[r].adr : 16'h0000;
            adr1   = (tbl[r].port == 1) ? tbl[r].adr : 16'h0000;
            CPWR   = tbl[r].wr ? pbit : 2'b00;
            CPREQ  = pbit;
            #1;
            chk($sformatf("v%0d_wait0", r), 32'(CPWAIT), 32'((tbl[r].exp_cs != 0) ? pbit : 2'b00));
            tick();
            chk($sformatf("v%0d_cs", r), 32'(cs), 32'(tbl[r].exp_cs));
            if (tbl[r].exp_cs != 0) begin
                chk($sformatf("v%0d_adr", r), 32'(BUS_ADR), 32'(tbl[r].adr));
                chk($sformatf("v%0d_wr", r), 32'(BUS_WR), 32'(tbl[r].wr));
                chk($sformatf("v%0d_grant", r), 32'(GRANT), 32'(tbl[r].port));
            end
            tick();
            chk($sformatf("v%0d_cs1", r), 32'(cs), 32'(tbl[r].exp_cs));
            chk($sformatf("v%0d_wait1", r), 32'(CPWAIT), 32'h0);
            CPREQ = 2'b00;
            tick();
            chk($sformatf("v%0d_idle", r), 32'(cs), 32'(C_NONE));
        end

        // Both ports hit PSG on RAIDERS5: strict rotation 0, 1, 0
        do_reset();
        HWTYPE = 2'd1;
        adr0   = 16'hC000;
        adr1   = 16'h8000;
        CPWR   = 2'b10;
        CPREQ  = 2'b11;
        tick();
        chk("rot_g0", 32'(GRANT), 32'h0);
        chk("rot_cs0", 32'(cs), 32'(C_PSG));
        chk("rot_wait_a", 32'(CPWAIT), 32'h3);
        tick();
        chk("rot_wait_b", 32'(CPWAIT), 32'h2);
        tick();
        chk("rot_idle0", 32'(cs), 32'(C_NONE));
        chk("rot_wait_c", 32'(CPWAIT), 32'h3);
        tick();
        chk("rot_g1", 32'(GRANT), 32'h1);
        chk("rot_adr1", 32'(BUS_ADR), 32'h8000);
        chk("rot_wr1", 32'(BUS_WR), 32'h1);
        chk("rot_cs1", 32'(cs), 32'(C_PSG));
        tick();
        chk("rot_wait_d", 32'(CPWAIT), 32'h1);
        tick();
        chk("rot_idle1", 32'(cs), 32'(C_NONE));
        tick();
        chk("rot_g2", 32'(GRANT), 32'h0);
        chk("rot_adr2", 32'(BUS_ADR), 32'hC000);
        CPREQ = 2'b00;
        tick();

        // Abort: request dropped in the first access cycle
        do_reset();
        HWTYPE = 2'd0;
        adr0   = 16'hC123;
        CPWR   = 2'b00;
        CPREQ  = 2'b01;
        tick();
        chk("abort_cs_on", 32'(cs), 32'(C_FGV));
        CPREQ = 2'b00;
        tick();
        chk("abort_cs_off", 32'(cs), 32'(C_NONE));

        // Reset mid-access restores port 0 priority
        do_reset();
        adr0  = 16'hC000;
        adr1  = 16'hC800;
        CPREQ = 2'b11;
        tick();
        chk("mrst_g0", 32'(GRANT), 32'h0);
        RESET = 1'b1;
        tick();
        chk("mrst_cs", 32'(cs), 32'(C_NONE));
        RESET = 1'b0;
        tick();
        chk("mrst_regrant", 32'(GRANT), 32'h0);
        chk("mrst_cs_fgv", 32'(cs), 32'(C_FGV));
        CPREQ = 2'b00;
        tick();

        // HWTYPE change during a granted access does not disturb the latched select
        do_reset();
        HWTYPE = 2'd3;
        adr0   = 16'h8800;
        adr1   = 16'h0000;
        CPREQ  = 2'b01;
        tick();
        chk("hwt_cs0", 32'(cs), 32'(C_BGV));
        HWTYPE = 2'd0;
        tick();
        chk("hwt_cs1", 32'(cs), 32'(C_BGV));
        tick();
        chk("hwt_idle", 32'(cs), 32'(C_NONE));
        CPREQ = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ninjakun_busarb.md
# ninjakun_busarb

Registered, multi-CPU successor to the Ninjakun-family address decoder. It decodes up to `NCPU` CPU address buses against the per-board device map selected by `HWTYPE`. When more than one CPU targets the shared video/sound devices, it arbitrates round-robin, inserts Z80 wait states for the losers, and drives registered chip selects plus a muxed device address. It sits between the CPU cores and the shared VRAM, sprite, palette, scroll and PSG blocks.

## Interface
Parameters:
- `NCPU`, default 2: number of CPU ports, 1..4; port 0 is the main CPU, ports ≥1 use the sub map.
- `HOLD`, default 2: device access length in clocks, 1..4.

Ports:
- `CLK` in 1: system clock; sole clock domain.
- `RESET` in 1: synchronous, active-high reset.
- `HWTYPE` in 2: board type, encoded per the shared `HW_*` defines (NINJAKUN, RAIDERS5, NOVA2001, PKUNWAR).
- `CPADR` in NCPU*16: packed CPU addresses; port i occupies bits [16i+15:16i].
- `CPREQ` in NCPU: memory request active (MREQ and (RD or WR)).
- `CPWR` in NCPU: write strobe qualifier.
- `CPWAIT` out NCPU: active-high wait to each CPU.
- `BUS_ADR` out 16: address of the granted access.
- `BUS_WR` out 1: write flag of the granted access.
- `GRANT` out 2: index of the granted CPU.
- `CS_SCRX`, `CS_SCRY`, `CS_PSG`, `CS_FGV`, `CS_BGV`, `CS_SPA`, `CS_PAL` out 1 each: registered one-hot device selects.

## Operation
Device map for port 0 (ranges inclusive):
- NINJAKUN, and any unlisted code: PSG 8000-8003, FGV C000-C7FF, BGV C800-CFFF, SPA D000-D7FF, PAL D800-DFFF.
- RAIDERS5: SCRX A000, SCRY A001, SPA 8000-87FF, FGV 8800-8FFF, BGV 9000-97FF, PSG C000-C003, PAL D000-D7FF.
- NOVA2001: FGV A000-A7FF, BGV A800-AFFF, SPA B000-B7FF, PSG C000-C003.
- PKUNWAR: SPA 8000-87FF, BGV 8800-8FFF, PSG A000-A003.

Device map for ports ≥1:
- NINJAKUN: same as port 0.
- RAIDERS5: SCRX E000, SCRY E001, PSG 8000-8003.
- NOVA2001 and PKUNWAR: no devices.

Behaviour:
- `hit[i]` = `CPREQ[i]` and port i's address falls in any device region. Non-hit requests (ROM, private RAM) get no select and no wait.
- FSM states: IDLE, ACCESS. Counter `cnt` is 2 bits. Round-robin pointer `rr` holds the index of the last grant.
- IDLE: if any `hit`, choose the first hitting port scanning `rr+1, rr+2, …` modulo NCPU. Then latch its address, `CPWR`, and decoded region (using `HWTYPE` at that edge), set `GRANT`/`rr`, set `cnt=0`, and go to ACCESS.
- ACCESS: the latched select is asserted one-hot. `cnt` increments each clock. When `cnt==HOLD-1`, the next edge returns to IDLE and clears all selects.
- Abort: if `CPREQ[GRANT]` is low at an edge in ACCESS, go to IDLE and clear selects at that edge.
- `HWTYPE` changes during ACCESS do not affect the latched select.
- `CPWAIT[i]` is combinational: `hit[i]` and not (state==ACCESS and `GRANT==i` and `cnt==HOLD-1`). It drops only in the final access cycle of the owning CPU.

## Timing
- Reset values: state IDLE, `rr=NCPU-1` (so port 0 wins first), `GRANT=0`, `cnt=0`, all CS 0, `BUS_ADR=0`, `BUS_WR=0`. `CPWAIT` follows `hit` and is therefore high for any device hit during reset.
- Grant latency: request seen at edge N → CS high after edge N+1... specifically, hit present in IDLE at edge N → selects, `BUS_ADR`, `GRANT` valid from edge N through edge N+HOLD.
- Back-to-back: ACCESS→IDLE→next grant costs one idle clock between accesses.
- `RESET` mid-ACCESS: next edge returns to IDLE with all CS 0, regardless of `cnt`.
- Simultaneous hits from all ports are served in strict rotation. No port waits more than (NCPU-1) accesses plus its own.

## Test plan
- Reset, HWTYPE=NINJAKUN, port 0 reads C123 alone, HOLD=2 → CS_FGV high 2 clocks, `BUS_ADR`=C123, `CPWAIT[0]` high one clock then low.
- HWTYPE=RAIDERS5: port 0 writes A001, then port 1 writes E000 → CS_SCRY then CS_SCRX, `BUS_WR`=1; port 0 address 8400 → CS_SPA.
- NCPU=2: both ports hit PSG (port 0 at C000, port 1 at 8000, RAIDERS5) on the same edge → port 0 granted first, port 1 waits 3 clocks then is granted; repeat and port 1 wins.
- HWTYPE=NOVA2001, port 1 at A000 with CPREQ high → no CS, `CPWAIT[1]`=0. Port 0 at 0100 → no CS, no wait.
- Abort and reset: drop `CPREQ[0]` in the first ACCESS cycle → CS cleared at the next edge. Separately, assert `RESET` mid-access → IDLE, all CS 0, next grant goes to port 0.
- HWTYPE toggled from PKUNWAR to NINJAKUN during a granted 8800 access → CS_BGV held for the full HOLD.
